// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy scoreboard for hazard detection.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  localparam int TAG_W   = $clog2(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_READ*TAG_W-1:0] rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic                      wr_en,
  input  logic [TAG_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      issue_en,
  input  logic [TAG_W-1:0]          issue_tag,
  input  logic                      flush,
  output logic [TAG_W:0]            busy_count
);

  logic [WIDTH-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [TAG_W:0]      r_busy_count;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_wr_ok;

  function automatic logic [TAG_W:0] popcount(input logic [NUM_REGS-1:0] bits);
    logic [TAG_W:0] cnt;
    cnt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt = cnt + (TAG_W+1)'(bits[r]);
    end
    return cnt;
  endfunction

  assign w_wr_ok = wr_en && (wr_addr != '0);

  // Issue wins over writeback on the same tag: the new producer supersedes the old one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_en && (issue_tag == TAG_W'(r))) begin
          w_busy_nxt[r] = 1'b1;
        end else if (w_wr_ok && (wr_addr == TAG_W'(r))) begin
          w_busy_nxt[r] = 1'b0;
        end
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= popcount(w_busy_nxt);
    end
  end

  assign busy_count = r_busy_count;

`ifdef REGFILE_BYPASS_EN
  logic w_reissue;
  assign w_reissue = issue_en && (issue_tag == wr_addr);
`endif

  genvar g;
  for (g = 0; g < NUM_READ; g++) begin : g_rd
    logic [TAG_W-1:0] w_addr;
    assign w_addr = rd_addr[g*TAG_W +: TAG_W];
`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    assign w_hit = w_wr_ok && (wr_addr == w_addr);
    assign rd_data[g*WIDTH +: WIDTH] = (w_addr == '0) ? '0 :
                                       (w_hit ? wr_data : r_regs[w_addr]);
    assign rd_busy[g] = r_busy[w_addr] & ~(w_hit & ~w_reissue);
`else
    assign rd_data[g*WIDTH +: WIDTH] = (w_addr == '0) ? '0 : r_regs[w_addr];
    assign rd_busy[g] = r_busy[w_addr];
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a reference model pushes expected reads
// into a queue that is drained and compared against the DUT outputs.
module tb_regfile_scoreboard;
  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_READ = 2;
  localparam int TAG_W    = 5;

  logic                      clock;
  logic                      reset_n;
  logic [NUM_READ*TAG_W-1:0] rd_addr;
  logic [NUM_READ*WIDTH-1:0] rd_data;
  logic [NUM_READ-1:0]       rd_busy;
  logic                      wr_en;
  logic [TAG_W-1:0]          wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic                      issue_en;
  logic [TAG_W-1:0]          issue_tag;
  logic                      flush;
  logic [TAG_W:0]            busy_count;

  regfile_scoreboard #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_READ(NUM_READ)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_tag(issue_tag), .flush(flush),
    .busy_count(busy_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          kind;   // 0 = rd_data, 1 = rd_busy, 2 = busy_count
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_reg  [NUM_REGS];
  logic        m_busy [NUM_REGS];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [TAG_W-1:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != 0 && wr_addr == a) return wr_data;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [TAG_W-1:0] a);
    logic b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a && !(issue_en && issue_tag == a)) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [31:0] model_count();
    int c;
    c = 0;
    for (int r = 0; r < NUM_REGS; r++) c += int'(m_busy[r]);
    return 32'(c);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic set_rd(input int p, input logic [TAG_W-1:0] a);
    rd_addr[p*TAG_W +: TAG_W] = a;
  endtask

  task automatic tick();
    @(posedge clock);
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_en && issue_tag == TAG_W'(r)) m_busy[r] = 1'b1;
        else if (wr_en && wr_addr == TAG_W'(r)) m_busy[r] = 1'b0;
      end
    end
    if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
    #1;
    wr_en    = 1'b0;
    issue_en = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic check_reads(input string name);
    exp_t e;
    #1;
    for (int p = 0; p < NUM_READ; p++) begin
      sb_q.push_back('{$sformatf("%s.data%0d", name, p), 0, p, exp_data(rd_addr[p*TAG_W +: TAG_W])});
      sb_q.push_back('{$sformatf("%s.busy%0d", name, p), 1, p, {31'b0, exp_busy(rd_addr[p*TAG_W +: TAG_W])}});
    end
    sb_q.push_back('{$sformatf("%s.count", name), 2, 0, model_count()});
    while (sb_q.size() > 0) begin
      logic [31:0] got;
      e = sb_q.pop_front();
      case (e.kind)
        0:       got = rd_data[e.port*WIDTH +: WIDTH];
        1:       got = {31'b0, rd_busy[e.port]};
        default: got = 32'(busy_count);
      endcase
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic do_write(input logic [TAG_W-1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_issue(input logic [TAG_W-1:0] t);
    issue_en = 1'b1; issue_tag = t;
  endtask

  initial begin
    reset_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_tag = '0; flush = 1'b0;
    model_clear();

    set_rd(0, 5'd0); set_rd(1, 5'd5);
    check_reads("in_reset");
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    do_write(5'd7, 32'h12345678); tick();
    for (int p = 0; p < NUM_READ; p++) set_rd(p, 5'd7);
    check_reads("wr7");
    do_write(5'd0, 32'hFFFFFFFF); tick();
    for (int p = 0; p < NUM_READ; p++) set_rd(p, 5'd0);
    check_reads("wr0");

    do_issue(5'd3); tick();
    set_rd(0, 5'd3); set_rd(1, 5'd7);
    check_reads("issue3");
    do_write(5'd3, 32'h000000A5); tick();
    check_reads("wb3");

    do_issue(5'd4); do_write(5'd4, 32'h11); tick();
    set_rd(0, 5'd4); set_rd(1, 5'd3);
    check_reads("iss_wb4");
    do_issue(5'd0); tick();
    check_reads("issue0");
    do_issue(5'd4); tick();
    check_reads("reissue4");
    do_write(5'd4, 32'h22); tick();
    do_write(5'd12, 32'h5555AAAA); tick();
    set_rd(0, 5'd12);
    check_reads("wb_idle12");

    do_issue(5'd1); tick();
    do_issue(5'd2); tick();
    do_issue(5'd9); tick();
    set_rd(0, 5'd1); set_rd(1, 5'd9);
    check_reads("mark3");
    flush = 1'b1; do_issue(5'd10); tick();
    set_rd(0, 5'd10); set_rd(1, 5'd9);
    check_reads("flush");

    do_issue(5'd6); tick();
    set_rd(0, 5'd6); set_rd(1, 5'd6);
    do_write(5'd6, 32'h77);
    check_reads("bypass6");
    tick();
    check_reads("after6");

    for (int i = 0; i < 60; i++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = TAG_W'($urandom_range(0, 7));
      wr_data   = $urandom;
      issue_en  = 1'($urandom_range(0, 1));
      issue_tag = TAG_W'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      set_rd(0, TAG_W'($urandom_range(0, 7)));
      set_rd(1, (i % 4 == 0) ? wr_addr : TAG_W'($urandom_range(0, 7)));
      check_reads($sformatf("rnd%0d", i));
      tick();
    end

    do_write(5'd5, 32'hDEADBEEF); tick();
    do_issue(5'd8); tick();
    set_rd(0, 5'd5); set_rd(1, 5'd8);
    check_reads("pre_rst");
    #1;
    reset_n = 1'b0;
    model_clear();
    check_reads("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_reads("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-write, two-read integer register file.
- Generalised in data width, register count and number of read ports.
- Adds asynchronous reset of register contents and a per-register busy scoreboard, set when an instruction issues and cleared at writeback, which the pipeline uses for hazard detection.
- Sits between the decode/issue stage (reads, issue marks) and the writeback stage (writes, busy clears). Register 0 is hard-wired zero and is never busy.

Parameters:
- WIDTH, 32, data bits per register.
- NUM_REGS, 32, number of architectural registers including register 0. Must be a power of two and ≥ 2.
- NUM_READ, 2, number of independent read ports.
- TAG_W, $clog2(NUM_REGS), localparam; register index width.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_READ*TAG_W  packed read indices; port i uses bits [i*TAG_W +: TAG_W].
- rd_data  out  NUM_READ*WIDTH  packed read data, port i at [i*WIDTH +: WIDTH].
- rd_busy  out  NUM_READ  busy flag of the addressed register per port.
- wr_en  in  1  writeback strobe.
- wr_addr  in  TAG_W  writeback destination.
- wr_data  in  WIDTH  writeback value.
- issue_en  in  1  marks issue_tag busy (producer in flight).
- issue_tag  in  TAG_W  destination of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits (pipeline flush); register contents untouched.
- busy_count  out  TAG_W+1  number of registers currently busy.

Behaviour:
- Reset (reset_n=0, asynchronous assert, synchronous-to-clock release): all registers = 0, all busy bits = 0.
  - Consequently rd_data = 0, rd_busy = 0, busy_count = 0 during and immediately after reset.
  - Reset mid-operation discards all pending writes and busy marks.
- Reads are combinational: rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
- Read of address 0: rd_data = 0 and rd_busy = 0, regardless of any other input.
- Write: on a clock edge with wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data.
  - Without bypass, the new value is visible on reads from the next cycle.
  - wr_addr=0 writes are dropped.
- Busy update on each clock edge, evaluated in this priority order:
  1. flush=1: all busy ← 0. Any issue_en in the same cycle is ignored. Writes still occur.
  2. Else, for each register r≠0:
     - set if issue_en and issue_tag=r;
     - else clear if wr_en and wr_addr=r;
     - else hold.
- Simultaneous issue and writeback to the same tag: busy stays 1, because the new producer supersedes the old one. The data write still happens.
- issue_tag=0: ignored.
- Issuing an already-busy register: stays busy (no counting; one bit per register).
- Writeback to a non-busy register: data written, busy stays 0.
- busy_count: registered population count of busy bits, updated in the same edge as the busy bits; it always equals popcount(busy). Maximum value NUM_REGS-1.
- All read ports are independent; several ports may address the same register.
- No stalls and no handshake: the block accepts one write and one issue per cycle, unconditionally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a write is forwarded within the same cycle.
  - If wr_en=1, wr_addr≠0 and rd_addr[i]=wr_addr, then rd_data[i]=wr_data combinationally.
  - rd_busy[i] = busy & ~(wr_en & wr_addr=rd_addr[i] & ~(issue_en & issue_tag=wr_addr)). In words: a register being written back this cycle reads as not busy, unless it is also being re-issued this cycle.
- Not defined: reads return the stored value only and rd_busy is the raw busy bit. This costs one extra cycle of visibility, and the pipeline inserts the stall.

Test Plan:
- Reset: pulse reset_n low mid-cycle after writing reg 5 = 0xDEADBEEF → rd_data for reg 5 = 0 immediately (asynchronous), busy_count = 0.
- Write/read: write reg 7 = 0x12345678; next cycle read it on all NUM_READ ports → 0x12345678 on each. Write reg 0 = 0xFFFFFFFF → reads of reg 0 return 0.
- Scoreboard: issue tag 3; next cycle rd_busy=1 and busy_count=1; writeback reg 3 = 0xA5 → next cycle rd_busy=0, busy_count=0, data 0xA5.
- Simultaneous events: issue tag 4 and writeback reg 4 = 0x11 in the same cycle → busy[4]=1, reg 4 = 0x11. Issue tag 0 → busy_count unchanged.
- Flush: mark tags 1, 2, 9 busy (busy_count=3); flush with issue tag 10 in the same cycle → busy_count=0, tag 10 not busy.
- Bypass (REGFILE_BYPASS_EN): tag 6 busy; same cycle as writing reg 6 = 0x77, read reg 6 → rd_data=0x77, rd_busy=0. Without the macro → old value and rd_busy=1.
